mac_seq: RTL and testbench
==========================

// Module: mac_seq
// PURPOSE
//  Parametrised sequential shift-add multiply-accumulate unit; next generation of the 32x32 multiply block.
//  Adds WIDTH generalisation, signed/unsigned mode, a wide accumulator with clear, and overflow reporting.
//  Sits between operand registers loaded by the controller and the result bus; handshake is s/Finish.
// PARAMETERS
//  WIDTH   32            operand width in bits (>=2)
//  ACC_W   2*WIDTH+8     accumulator width in bits (>=2*WIDTH)
// PORTS
//  clk      in   1        rising-edge clock
//  reset    in   1        synchronous, active-high reset
//  LA       in   1        load DataA into operand register A
//  LB       in   1        load DataB into operand register B
//  s        in   1        start (level); must stay high until Finish is seen
//  sgn      in   1        1 = two's-complement operands, 0 = unsigned; sampled at start
//  acc_clr  in   1        1 = clear the accumulator (see BEHAVIOUR)
//  DataA    in   WIDTH    operand A data
//  DataB    in   WIDTH    operand B data
//  P        out  2*WIDTH  product of the last operation
//  Acc      out  ACC_W    accumulator
//  Finish   out  1        operation complete; P and Acc valid
//  busy     out  1        high in MUL and ACC states
//  ovf      out  1        sticky accumulator overflow flag
// BEHAVIOUR
//  - Reset: state=IDLE; A, B, P, Acc, ovf = 0; Finish = 0; busy = 0. Reset has priority in every state, including mid-operation.
//  - States: IDLE -> MUL -> ACC -> DONE -> IDLE.
//  - IDLE
//    - LA/LB load A/B.
//    - acc_clr with s=0 clears Acc and ovf next edge.
//    - s=1: go to MUL; latch sgn; cnt=0; working regs take DataA/DataB if LA/LB are high that same edge, else A/B.
//  - MUL
//    - Operands are reduced to magnitudes (two's-complement negate when sgn and MSB=1); sign flag = a_msb ^ b_msb.
//    - One multiplier bit per cycle: add shifted multiplicand when the LSB is 1; exactly WIDTH cycles.
//    - LA, LB and acc_clr are ignored in MUL and ACC.
//  - ACC (1 cycle)
//    - P = sign ? -mag : mag.
//    - Acc = base + ext(P): ext = sign-extend if sgn, else zero-extend.
//    - base = 0 if acc_clr was high at the start edge, else the previous Acc.
//  - DONE: Finish=1, held while s=1; s=0 -> IDLE with Finish=0 next edge. LA/LB are accepted in DONE.
//  - Latency: start sampled at edge k -> Finish visible after edge k+WIDTH+1. P and Acc are stable from then until the next start.
//  - Most-negative operand: magnitude 2^(WIDTH-1) in WIDTH bits, no overflow. Product always fits 2*WIDTH bits.
//  - Overflow
//    - Detected on the Acc add: signed overflow if sgn, else unsigned carry out of ACC_W.
//    - ovf is sticky; cleared only by reset or acc_clr.
// CONFIGURATION
//  MAC_SATURATE_EN
//    - defined: on overflow Acc clamps. Signed mode clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1); unsigned mode clamps to 2^ACC_W-1. ovf is set.
//    - undefined: Acc wraps modulo 2^ACC_W; ovf is still set.
// TESTING
//  1. WIDTH=32, sgn=0, acc_clr=1: A=123, B=156, s=1 -> P=19188 (0x4AF4), Acc=19188; Finish exactly 33 edges after the start edge; busy high 33 cycles.
//  2. sgn=1: A=-3 (0xFFFFFFFF_FFFFFFFD truncated to 32b), B=5 -> P=0xFFFFFFFF_FFFFFFF1 (-15); Acc sign-extended = -15.
//  3. After test 1, acc_clr=0: A=2, B=3 -> P=6, Acc=19194; ovf=0.
//  4. Reset asserted in MUL at cnt=10 -> next edge IDLE, P=0, Acc=0, Finish=0, busy=0. A new start then completes normally.
//  5. WIDTH=8, ACC_W=16, sgn=1: 127*127 three times (first with acc_clr) -> Acc 16129, 32258, then 32767 with ovf=1 (macro defined) / 0xBD03 with ovf=1 (macro undefined).
//  6. Handshake: hold s high 5 cycles after Finish -> Finish stays 1, no restart; LA during MUL -> A unchanged, result unaffected; -128*-128 (WIDTH=8) -> P=16384.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: sequential shift-add multiply-accumulate unit.
// One multiplier bit per cycle on operand magnitudes, sign reapplied in ACC,
// wide accumulator with clear and sticky overflow.
// Optional feature: define MAC_SATURATE_EN to clamp Acc on overflow instead of wrapping.
module mac_seq #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 2*WIDTH+8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LA,
    input  logic               LB,
    input  logic               s,
    input  logic               sgn,
    input  logic               acc_clr,
    input  logic [WIDTH-1:0]   DataA,
    input  logic [WIDTH-1:0]   DataB,
    output logic [2*WIDTH-1:0] P,
    output logic [ACC_W-1:0]   Acc,
    output logic               Finish,
    output logic               busy,
    output logic               ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   A, B;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               sgn_r;
    logic               clr_r;
    logic               neg;

    logic [WIDTH-1:0]   sel_a, sel_b, mag_a, mag_b;
    logic [2*WIDTH-1:0] p_res;
    logic [ACC_W-1:0]   p_ext, base, acc_next;
    logic [ACC_W:0]     sum;
    logic               of;

    // Operand selection and magnitude reduction for the start edge
    always_comb begin
        sel_a = LA ? DataA : A;
        sel_b = LB ? DataB : B;
        mag_a = (sgn && sel_a[WIDTH-1]) ? ('0 - sel_a) : sel_a;
        mag_b = (sgn && sel_b[WIDTH-1]) ? ('0 - sel_b) : sel_b;
    end

    // Signed product, accumulator add, overflow detection and clamp/wrap
    always_comb begin
        p_res = neg ? ('0 - prod) : prod;
        p_ext = sgn_r ? ACC_W'($signed(p_res)) : ACC_W'(p_res);
        base  = clr_r ? '0 : Acc;
        sum   = {1'b0, base} + {1'b0, p_ext};
        if (sgn_r)
            of = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
        else
            of = sum[ACC_W];
`ifdef MAC_SATURATE_EN
        if (of) begin
            if (sgn_r)
                acc_next = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}};
            else
                acc_next = '1;
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
`else
        acc_next = sum[ACC_W-1:0];
`endif
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            A      <= '0;
            B      <= '0;
            P      <= '0;
            Acc    <= '0;
            ovf    <= 1'b0;
            Finish <= 1'b0;
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            sgn_r  <= 1'b0;
            clr_r  <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (LA) A <= DataA;
                    if (LB) B <= DataB;
                    if (s) begin
                        state  <= MUL;
                        busy   <= 1'b1;
                        sgn_r  <= sgn;
                        clr_r  <= acc_clr;
                        cnt    <= '0;
                        mcand  <= (2*WIDTH)'(mag_a);
                        mplier <= mag_b;
                        prod   <= '0;
                        neg    <= sgn & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
                    end else if (acc_clr) begin
                        Acc <= '0;
                        ovf <= 1'b0;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= ACC;
                end
                ACC: begin
                    P      <= p_res;
                    Acc    <= acc_next;
                    ovf    <= (ovf & ~clr_r) | of;
                    busy   <= 1'b0;
                    Finish <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (LA) A <= DataA;
                    if (LB) B <= DataB;
                    if (!s) begin
                        Finish <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed self-checking bench for mac_seq (WIDTH=32 and WIDTH=8 instances).
module tb_mac_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 32-bit instance
    logic        rst32, la32, lb32, s32, sgn32, clr32;
    logic [31:0] da32, db32;
    logic [63:0] p32;
    logic [71:0] acc32;
    logic        fin32, busy32, ovf32;

    // 8-bit instance, 16-bit accumulator
    logic        rst8, la8, lb8, s8, sgn8, clr8;
    logic [7:0]  da8, db8;
    logic [15:0] p8;
    logic [15:0] acc8;
    logic        fin8, busy8, ovf8;

    mac_seq #(.WIDTH(32), .ACC_W(72)) dut32 (
        .clk(clk), .reset(rst32), .LA(la32), .LB(lb32), .s(s32), .sgn(sgn32),
        .acc_clr(clr32), .DataA(da32), .DataB(db32), .P(p32), .Acc(acc32),
        .Finish(fin32), .busy(busy32), .ovf(ovf32)
    );

    mac_seq #(.WIDTH(8), .ACC_W(16)) dut8 (
        .clk(clk), .reset(rst8), .LA(la8), .LB(lb8), .s(s8), .sgn(sgn8),
        .acc_clr(clr8), .DataA(da8), .DataB(db8), .P(p8), .Acc(acc8),
        .Finish(fin8), .busy(busy8), .ovf(ovf8)
    );

    // Start an operation on the 32-bit unit and wait (bounded) for Finish.
    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic clr, output int edges, output int bcyc);
        la32 = 1'b1; lb32 = 1'b1; da32 = a; db32 = b; sgn32 = sg; clr32 = clr; s32 = 1'b1;
        @(posedge clk); #1;
        la32 = 1'b0; lb32 = 1'b0; clr32 = 1'b0;
        edges = 0; bcyc = 0;
        while (!fin32 && edges < 200) begin
            if (busy32) bcyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sg,
                       input logic clr, input logic ld, output int edges);
        la8 = ld; lb8 = ld; da8 = a; db8 = b; sgn8 = sg; clr8 = clr; s8 = 1'b1;
        @(posedge clk); #1;
        la8 = 1'b0; lb8 = 1'b0; clr8 = 1'b0;
        edges = 0;
        while (!fin8 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        rst32 = 1'b1; rst8 = 1'b1;
        la32 = 0; lb32 = 0; s32 = 0; sgn32 = 0; clr32 = 0; da32 = '0; db32 = '0;
        la8 = 0; lb8 = 0; s8 = 0; sgn8 = 0; clr8 = 0; da8 = '0; db8 = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (p32 !== 64'd0) begin fails++; $display("FAIL reset_p got %h want 0", p32); end
        tests++; if (acc32 !== 72'd0) begin fails++; $display("FAIL reset_acc got %h want 0", acc32); end
        tests++; if ({fin32, busy32, ovf32} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {fin32, busy32, ovf32}); end
        tests++; if ({fin8, busy8, ovf8, acc8} !== 19'd0) begin fails++; $display("FAIL reset8 got %h want 0", {fin8, busy8, ovf8, acc8}); end
        rst32 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        int e, b;
        go32(32'd123, 32'd156, 1'b0, 1'b1, e, b);
        tests++; if (e !== 33) begin fails++; $display("FAIL t1_latency got %0d want 33", e); end
        tests++; if (b !== 33) begin fails++; $display("FAIL t1_busy_cycles got %0d want 33", b); end
        tests++; if (p32 !== 64'h4AF4) begin fails++; $display("FAIL t1_p got %h want 4af4", p32); end
        tests++; if (acc32 !== 72'd19188) begin fails++; $display("FAIL t1_acc got %0d want 19188", acc32); end
        s32 = 1'b0; @(posedge clk); #1;
        tests++; if (fin32 !== 1'b0) begin fails++; $display("FAIL t1_finish_drop got %b want 0", fin32); end
        // accumulate without clear
        go32(32'd2, 32'd3, 1'b0, 1'b0, e, b);
        tests++; if (p32 !== 64'd6) begin fails++; $display("FAIL t3_p got %0d want 6", p32); end
        tests++; if (acc32 !== 72'd19194) begin fails++; $display("FAIL t3_acc got %0d want 19194", acc32); end
        tests++; if (ovf32 !== 1'b0) begin fails++; $display("FAIL t3_ovf got %b want 0", ovf32); end
        s32 = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_signed;
        int e, b;
        logic [71:0] exp_acc;
        exp_acc = 72'd0 - 72'd15;
        go32(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, e, b);
        tests++; if (p32 !== 64'hFFFF_FFFF_FFFF_FFF1) begin fails++; $display("FAIL t2_p got %h want fffffffffffffff1", p32); end
        tests++; if (acc32 !== exp_acc) begin fails++; $display("FAIL t2_acc got %h want %h", acc32, exp_acc); end
        tests++; if (e !== 33) begin fails++; $display("FAIL t2_latency got %0d want 33", e); end
        s32 = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int e, b;
        la32 = 1'b1; lb32 = 1'b1; da32 = 32'd2; db32 = 32'd3; sgn32 = 1'b0; clr32 = 1'b1; s32 = 1'b1;
        @(posedge clk); #1;
        la32 = 1'b0; lb32 = 1'b0; clr32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst32 = 1'b1; s32 = 1'b0;
        @(posedge clk); #1;
        rst32 = 1'b0;
        tests++; if (p32 !== 64'd0) begin fails++; $display("FAIL t4_p got %h want 0", p32); end
        tests++; if (acc32 !== 72'd0) begin fails++; $display("FAIL t4_acc got %h want 0", acc32); end
        tests++; if ({fin32, busy32} !== 2'b00) begin fails++; $display("FAIL t4_flags got %b want 00", {fin32, busy32}); end
        go32(32'd2, 32'd3, 1'b0, 1'b0, e, b);
        tests++; if (e !== 33) begin fails++; $display("FAIL t4_restart_latency got %0d want 33", e); end
        tests++; if ({p32, acc32} !== {64'd6, 72'd6}) begin fails++; $display("FAIL t4_restart got p=%0d acc=%0d want 6/6", p32, acc32); end
        s32 = 1'b0; @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int e;
        logic [15:0] exp3;
`ifdef MAC_SATURATE_EN
        exp3 = 16'h7FFF;
`else
        exp3 = 16'hBD03;
`endif
        go8(8'd127, 8'd127, 1'b1, 1'b1, 1'b1, e);
        tests++; if (e !== 9) begin fails++; $display("FAIL t5_latency got %0d want 9", e); end
        tests++; if ({p8, acc8} !== {16'h3F01, 16'd16129}) begin fails++; $display("FAIL t5_op1 got p=%h acc=%0d want 3f01/16129", p8, acc8); end
        s8 = 1'b0; @(posedge clk); #1;
        go8(8'd127, 8'd127, 1'b1, 1'b0, 1'b1, e);
        tests++; if ({acc8, ovf8} !== {16'd32258, 1'b0}) begin fails++; $display("FAIL t5_op2 got acc=%0d ovf=%b want 32258/0", acc8, ovf8); end
        s8 = 1'b0; @(posedge clk); #1;
        go8(8'd127, 8'd127, 1'b1, 1'b0, 1'b1, e);
        tests++; if ({acc8, ovf8} !== {exp3, 1'b1}) begin fails++; $display("FAIL t5_op3 got acc=%h ovf=%b want %h/1", acc8, ovf8, exp3); end
        s8 = 1'b0; @(posedge clk); #1;
        // ovf stays set across idle cycles until cleared
        @(posedge clk); #1;
        tests++; if (ovf8 !== 1'b1) begin fails++; $display("FAIL t5_sticky got %b want 1", ovf8); end
        clr8 = 1'b1; @(posedge clk); #1; clr8 = 1'b0;
        tests++; if ({acc8, ovf8} !== 17'd0) begin fails++; $display("FAIL t5_idle_clear got acc=%h ovf=%b want 0/0", acc8, ovf8); end
    endtask

    task automatic test_handshake;
        int e;
        la8 = 1'b1; lb8 = 1'b1; da8 = 8'd7; db8 = 8'd9; sgn8 = 1'b0; clr8 = 1'b1; s8 = 1'b1;
        @(posedge clk); #1;
        // LA pulsed during MUL must not disturb A or the running product
        lb8 = 1'b0; clr8 = 1'b0; da8 = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        la8 = 1'b0;
        e = 2;
        while (!fin8 && e < 100) begin @(posedge clk); #1; e++; end
        tests++; if (e !== 9) begin fails++; $display("FAIL t6_latency got %0d want 9", e); end
        tests++; if (p8 !== 16'd63) begin fails++; $display("FAIL t6_p got %0d want 63", p8); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if ({fin8, busy8, p8} !== {1'b1, 1'b0, 16'd63}) begin fails++; $display("FAIL t6_hold%0d got fin=%b busy=%b p=%0d want 1/0/63", i, fin8, busy8, p8); end
        end
        s8 = 1'b0; @(posedge clk); #1;
        tests++; if (fin8 !== 1'b0) begin fails++; $display("FAIL t6_finish_drop got %b want 0", fin8); end
        // start without loading: uses held A=7, B=9
        go8(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, e);
        tests++; if (p8 !== 16'd63) begin fails++; $display("FAIL t6_a_unchanged got %0d want 63", p8); end
        s8 = 1'b0; @(posedge clk); #1;
        go8(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, e);
        tests++; if ({p8, acc8, ovf8} !== {16'd16384, 16'd16384, 1'b0}) begin fails++; $display("FAIL t6_mostneg got p=%0d acc=%0d ovf=%b want 16384/16384/0", p8, acc8, ovf8); end
        s8 = 1'b0; @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_mid_reset;
        test_overflow;
        test_handshake;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
